// File: rtl/spram_arbiter_pkg.sv
// rtl/spram_arbiter_pkg.sv - shared constants, grant encoding and nibble-merge helper for the SPRAM arbiter
package spram_arbiter_pkg;

    localparam int SPRAM_ADDR_BITS = 14;
    localparam int SPRAM_DATA_BITS = 16;
    localparam int SPRAM_MASK_BITS = 4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_RD   = 2'd1,
        GRANT_WR   = 2'd2
    } grant_e;

    // Each mask bit enables one 4-bit nibble of the word.
    function automatic logic [SPRAM_DATA_BITS-1:0] nibble_merge(
        input logic [SPRAM_DATA_BITS-1:0] old_word,
        input logic [SPRAM_DATA_BITS-1:0] new_word,
        input logic [SPRAM_MASK_BITS-1:0] mask
    );
        logic [SPRAM_DATA_BITS-1:0] merged;
        merged = old_word;
        for (int n = 0; n < SPRAM_MASK_BITS; n++) begin
            if (mask[n]) begin
                merged[4*n +: 4] = new_word[4*n +: 4];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/spram_32k.sv
// rtl/spram_32k.sv - 16-bit x 16K single-port RAM with nibble write mask and registered read data
module spram_32k
    import spram_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cs,
    input  logic                       wen,
    input  logic [SPRAM_ADDR_BITS-1:0] addr,
    input  logic [SPRAM_DATA_BITS-1:0] din,
    input  logic [SPRAM_MASK_BITS-1:0] mask,
    output logic [SPRAM_DATA_BITS-1:0] dout
);

    localparam int DEPTH = 1 << SPRAM_ADDR_BITS;

    logic [SPRAM_DATA_BITS-1:0] mem_q [0:DEPTH-1];
    logic [SPRAM_DATA_BITS-1:0] dout_q;
    logic [SPRAM_DATA_BITS-1:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (cs && !wen && !reset) begin
            dout_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    always_ff @(posedge clk) begin
        if (cs && wen && !reset) begin
            mem_q[addr] <= nibble_merge(mem_q[addr], din, mask);
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - read-priority SPRAM arbiter with one-entry write buffer and bounded write wait
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = SPRAM_ADDR_BITS,
    parameter int DATA_BITS = SPRAM_DATA_BITS,
    parameter int MAX_WAIT  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [3:0]           wr_mask,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_data_valid,
    output logic                 wr_starved
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic                 wbuf_full_q, wbuf_full_d;
    logic [ADDR_BITS-1:0] wbuf_addr_q, wbuf_addr_d;
    logic [DATA_BITS-1:0] wbuf_data_q, wbuf_data_d;
    logic [3:0]           wbuf_mask_q, wbuf_mask_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic                 rd_data_valid_q, rd_data_valid_d;

    grant_e               grant;
    logic                 force_wr;
    logic                 wr_accept;
    logic                 spram_cs;
    logic                 spram_wen;
    logic [ADDR_BITS-1:0] spram_addr;

    always_comb begin
        force_wr = wbuf_full_q && (wait_cnt_q == MAX_WAIT_C);
        grant    = GRANT_NONE;
        if (rd_valid && !force_wr) begin
            grant = GRANT_RD;
        end else if (wbuf_full_q) begin
            grant = GRANT_WR;
        end
        rd_ready   = !force_wr;
        // Draining the buffer this cycle frees it for a same-cycle reload.
        wr_ready   = !wbuf_full_q || (grant == GRANT_WR);
        wr_accept  = wr_valid && wr_ready;
        wr_starved = force_wr && rd_valid;
    end

    always_comb begin
        wbuf_full_d = wbuf_full_q;
        wbuf_addr_d = wbuf_addr_q;
        wbuf_data_d = wbuf_data_q;
        wbuf_mask_d = wbuf_mask_q;
        wait_cnt_d  = wait_cnt_q;
        if (grant == GRANT_WR) begin
            wbuf_full_d = 1'b0;
        end
        if (wr_accept) begin
            wbuf_full_d = 1'b1;
            wbuf_addr_d = wr_addr;
            wbuf_data_d = wr_data;
            wbuf_mask_d = wr_mask;
        end
        if (!wbuf_full_q || (grant == GRANT_WR)) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        rd_data_valid_d = (grant == GRANT_RD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_full_q     <= 1'b0;
            wait_cnt_q      <= 8'd0;
            rd_data_valid_q <= 1'b0;
        end else begin
            wbuf_full_q     <= wbuf_full_d;
            wbuf_addr_q     <= wbuf_addr_d;
            wbuf_data_q     <= wbuf_data_d;
            wbuf_mask_q     <= wbuf_mask_d;
            wait_cnt_q      <= wait_cnt_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    always_comb begin
        spram_cs   = !reset && (grant != GRANT_NONE);
        spram_wen  = (grant == GRANT_WR);
        spram_addr = spram_wen ? wbuf_addr_q : rd_addr;
    end

    spram_32k u_spram (
        .clk   (clk),
        .reset (reset),
        .cs    (spram_cs),
        .wen   (spram_wen),
        .addr  (spram_addr),
        .din   (wbuf_data_q),
        .mask  (wbuf_mask_q),
        .dout  (rd_data)
    );

    assign rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - self-checking bench: directed vector table, reset/starvation sequences, randomized model run
module tb_spram_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  wr_mask;
    logic        rd_valid;
    logic        rd_ready;
    logic [13:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic        wr_starved;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.ADDR_BITS(14), .DATA_BITS(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .wr_starved    (wr_starved)
    );

    typedef struct {
        logic        rst;
        logic        wv;
        logic [13:0] wa;
        logic [15:0] wd;
        logic [3:0]  wm;
        logic        rv;
        logic [13:0] ra;
        logic        e_rdy;
        logic        e_wrdy;
        logic        e_st;
        logic        e_rdv;
        logic [15:0] e_data;
    } vec_t;

    vec_t vt[$];

    // Reference model: memory image plus a pending write stamped with the cycle it became buffered.
    logic [15:0] ref_mem [16];
    bit          pend;
    logic [3:0]  p_addr;
    logic [15:0] p_data;
    logic [3:0]  p_mask;
    int          p_since;
    int          cyc;
    bit          prev_gr;
    logic [15:0] prev_exp;

    function automatic vec_t mk(input logic wv, input logic [13:0] wa, input logic [15:0] wd,
                                input logic [3:0] wm, input logic rv, input logic [13:0] ra,
                                input logic e_rdy, input logic e_wrdy, input logic e_st,
                                input logic e_rdv, input logic [15:0] e_data);
        vec_t v;
        v.rst = 1'b0; v.wv = wv; v.wa = wa; v.wd = wd; v.wm = wm; v.rv = rv; v.ra = ra;
        v.e_rdy = e_rdy; v.e_wrdy = e_wrdy; v.e_st = e_st; v.e_rdv = e_rdv; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic wv, input logic [13:0] wa, input logic [15:0] wd,
                         input logic [3:0] wm, input logic rv, input logic [13:0] ra);
        reset = rst; wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_valid = rv; rd_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mstep(input logic wv, input logic [3:0] wa, input logic [15:0] wd, input logic [3:0] wm,
                         input logic rv, input logic [3:0] ra,
                         output logic o_rdy, output logic o_st, output logic o_rdv);
        bit frc, rd_gr, wr_iss, e_wrdy;
        frc    = pend && ((cyc - p_since) >= MAX_WAIT);
        rd_gr  = rv && !frc;
        wr_iss = pend && !rd_gr;
        e_wrdy = !pend || wr_iss;
        drive(1'b0, wv, {10'd0, wa}, wd, wm, rv, {10'd0, ra});
        #4;
        chk("m_rd_ready", 32'(rd_ready), 32'(!frc));
        chk("m_wr_ready", 32'(wr_ready), 32'(e_wrdy));
        chk("m_wr_starved", 32'(wr_starved), 32'(frc && rv));
        chk("m_rd_data_valid", 32'(rd_data_valid), 32'(prev_gr));
        if (prev_gr) chk("m_rd_data", 32'(rd_data), 32'(prev_exp));
        o_rdy = rd_ready; o_st = wr_starved; o_rdv = rd_data_valid;
        if (rd_gr) prev_exp = ref_mem[ra];
        if (wr_iss) begin
            for (int n = 0; n < 4; n++)
                if (p_mask[n]) ref_mem[p_addr][4*n +: 4] = p_data[4*n +: 4];
            pend = 1'b0;
        end
        if (wv && e_wrdy) begin
            pend = 1'b1; p_addr = wa; p_data = wd; p_mask = wm; p_since = cyc + 1;
        end
        prev_gr = rd_gr;
        cyc++;
        tick();
    endtask

    initial begin
        logic o_rdy, o_st, o_rdv;
        int   n_low, low_idx, st_idx, pulses;
        logic [15:0] burst_data;

        drive(1'b1, 1'b0, 14'd0, 16'd0, 4'd0, 1'b0, 14'd0);
        tick(); tick();

        //          wv  wa     wd        wm     rv  ra     rdy wrdy st  rdv data
        vt.push_back(mk(1, 14'd5, 16'h1234, 4'hF, 0, 14'd0, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(1, 14'd9, 16'h1111, 4'hF, 0, 14'd0, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 0, 14'd0, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 1, 14'd5, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 1, 14'd9, 1,  1,   0,  1,  16'h1234));
        vt.push_back(mk(1, 14'd7, 16'hFFFF, 4'hF, 0, 14'd0, 1,  1,   0,  1,  16'h1111));
        vt.push_back(mk(1, 14'd7, 16'h0000, 4'h3, 0, 14'd0, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 0, 14'd0, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(1, 14'd9, 16'hABCD, 4'hF, 1, 14'd7, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 1, 14'd9, 1,  0,   0,  1,  16'hFF00));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 0, 14'd0, 1,  1,   0,  1,  16'h1111));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 1, 14'd9, 1,  1,   0,  0,  16'h0));
        vt.push_back(mk(0, 14'd0, 16'h0000, 4'h0, 0, 14'd0, 1,  1,   0,  1,  16'hABCD));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].wm, vt[i].rv, vt[i].ra);
            #4;
            chk($sformatf("v%0d_rd_ready", i), 32'(rd_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vt[i].e_wrdy));
            chk($sformatf("v%0d_wr_starved", i), 32'(wr_starved), 32'(vt[i].e_st));
            chk($sformatf("v%0d_rd_data_valid", i), 32'(rd_data_valid), 32'(vt[i].e_rdv));
            if (vt[i].e_rdv) chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vt[i].e_data));
            tick();
        end

        // Reset while a write is buffered and a read is being granted.
        drive(1'b0, 1'b1, 14'd3, 16'h5555, 4'hF, 1'b0, 14'd0); tick();
        drive(1'b0, 1'b0, 14'd0, 16'h0000, 4'h0, 1'b0, 14'd0); tick();
        drive(1'b0, 1'b1, 14'd3, 16'hAAAA, 4'hF, 1'b0, 14'd0); tick();
        drive(1'b0, 1'b0, 14'd0, 16'h0000, 4'h0, 1'b1, 14'd4); #4;
        chk("rst_pre_rd_ready", 32'(rd_ready), 32'd1);
        chk("rst_pre_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        drive(1'b1, 1'b0, 14'd0, 16'h0000, 4'h0, 1'b1, 14'd3); #4;
        chk("rst_cycle_rd_data_valid", 32'(rd_data_valid), 32'd1);
        tick();
        drive(1'b0, 1'b0, 14'd0, 16'h0000, 4'h0, 1'b0, 14'd0); #4;
        chk("rst_after_rd_data_valid", 32'(rd_data_valid), 32'd0);
        chk("rst_after_rd_ready", 32'(rd_ready), 32'd1);
        chk("rst_after_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_after_wr_starved", 32'(wr_starved), 32'd0);
        tick();
        drive(1'b0, 1'b0, 14'd0, 16'h0000, 4'h0, 1'b1, 14'd3); tick();
        drive(1'b0, 1'b0, 14'd0, 16'h0000, 4'h0, 1'b0, 14'd0); #4;
        chk("rst_dropped_write_rd_data_valid", 32'(rd_data_valid), 32'd1);
        chk("rst_dropped_write_rd_data", 32'(rd_data), 32'h5555);
        tick();
        tick();

        pend = 1'b0; prev_gr = 1'b0; cyc = 0; p_since = 0;
        p_addr = '0; p_data = '0; p_mask = '0; prev_exp = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;

        // Burst of 16 writes then readback.
        for (int i = 0; i < 16; i++) begin
            burst_data = 16'($urandom);
            mstep(1'b1, 4'(i), burst_data, 4'hF, 1'b0, 4'd0, o_rdy, o_st, o_rdv);
        end
        mstep(1'b0, 4'd0, 16'h0, 4'h0, 1'b0, 4'd0, o_rdy, o_st, o_rdv);
        for (int i = 0; i < 16; i++)
            mstep(1'b0, 4'd0, 16'h0, 4'h0, 1'b1, 4'(i), o_rdy, o_st, o_rdv);
        mstep(1'b0, 4'd0, 16'h0, 4'h0, 1'b0, 4'd0, o_rdy, o_st, o_rdv);

        // Continuous reads for 20 cycles with one write alongside.
        n_low = 0; low_idx = -1; st_idx = -1; pulses = 0;
        for (int c = 0; c < 20; c++) begin
            mstep(c == 0, 4'd10, 16'h7777, 4'hF, 1'b1, 4'(c % 16), o_rdy, o_st, o_rdv);
            if (!o_rdy) begin n_low++; low_idx = c; end
            if (o_st) st_idx = c;
            if (o_rdv) pulses++;
        end
        mstep(1'b0, 4'd0, 16'h0, 4'h0, 1'b0, 4'd0, o_rdy, o_st, o_rdv);
        if (o_rdv) pulses++;
        chk("starve_rd_ready_low_count", 32'(n_low), 32'd1);
        chk("starve_rd_ready_low_cycle", 32'(low_idx), 32'(MAX_WAIT + 1));
        chk("starve_wr_starved_cycle", 32'(st_idx), 32'(MAX_WAIT + 1));
        chk("starve_read_pulses", 32'(pulses), 32'd19);

        // Randomized traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            mstep(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  o_rdy, o_st, o_rdv);
        end
        mstep(1'b0, 4'd0, 16'h0, 4'h0, 1'b0, 4'd0, o_rdy, o_st, o_rdv);
        mstep(1'b0, 4'd0, 16'h0, 4'h0, 1'b0, 4'd0, o_rdy, o_st, o_rdv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
